// File: rtl/spi_rx_16.sv
// -----------------------------------------------------------------------------
// spi_rx_16
//   SPI receive end for the serial link driven by the SPI transmitter. A frame
//   is marked by cs_n low. mosi is sampled MSB first on each sclk rising edge,
//   and a DATA_W-bit word is rebuilt from it. The first LEAD_BITS cs_n-low
//   slots of each frame carry stale data and are skipped. Each completed word
//   is held on a valid/ready output until it is accepted.
//
//   This block runs in the transmitter's sclk domain, so it has no
//   synchronizers.
//
// Ports
//   sclk        clock; all logic runs on the rising edge
//   reset       synchronous, active-high reset
//   mosi        serial data
//   cs_n        frame select, active low
//   data_ready  downstream accepts data_out
//   data_out    received word (keeps its last value after acceptance)
//   data_valid  data_out holds a word that has not been accepted
//   frame_err   one-cycle pulse: cs_n rose before a full word was captured
//   overrun     one-cycle pulse: a completed word was dropped (output full)
//   rx_active   high while skipping lead slots or shifting data bits
// -----------------------------------------------------------------------------
module spi_rx_16 #(
   parameter int DATA_W    = 16,
   parameter int LEAD_BITS = 1
) (
   input  logic              sclk,
   input  logic              reset,
   input  logic              mosi,
   input  logic              cs_n,
   input  logic              data_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              frame_err,
   output logic              overrun,
   output logic              rx_active
);

   // Counter width is large enough to hold DATA_W+LEAD_BITS without wrapping.
   localparam int CNT_W = $clog2(DATA_W + LEAD_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] LEAD_CNT = CNT_W'(LEAD_BITS);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   typedef enum logic [2:0] {
      WAIT_HIGH,
      IDLE,
      SKIP,
      SHIFT,
      DONE
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] shift;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  skip_cnt;

   // This is the word as it stands after the bit on the current edge is shifted in.
   logic [DATA_W-1:0] word_next;
   logic              word_done;

   assign word_next = {shift[DATA_W-2:0], mosi};
   // This edge captures bit DATA_W, so the word is complete.
   assign word_done = (state == SHIFT) && !cs_n && (bit_cnt == LAST_BIT);

   assign rx_active = (state == SKIP) || (state == SHIFT);

   always_ff @(posedge sclk) begin
      if (reset) begin
         state      <= WAIT_HIGH;
         shift      <= '0;
         bit_cnt    <= '0;
         skip_cnt   <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         case (state)
            // After a reset, the receiver waits for cs_n high. A frame cut by
            // the reset is dropped without a flag.
            WAIT_HIGH: begin
               if (cs_n)
                  state <= IDLE;
            end

            // Slot 0 of a new frame.
            IDLE: begin
               if (!cs_n) begin
                  if (LEAD_BITS == 0) begin
                     shift   <= word_next;
                     bit_cnt <= ONE;
                     state   <= SHIFT;
                  end else if (LEAD_BITS == 1) begin
                     // Slot 0 uses up the whole lead. The next slot is the MSB,
                     // so go straight to SHIFT.
                     skip_cnt <= ONE;
                     bit_cnt  <= '0;
                     state    <= SHIFT;
                  end else begin
                     skip_cnt <= ONE;
                     bit_cnt  <= '0;
                     state    <= SKIP;
                  end
               end
            end

            SKIP: begin
               if (cs_n) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else begin
                  skip_cnt <= skip_cnt + ONE;
                  if (skip_cnt + ONE == LEAD_CNT) begin
                     bit_cnt <= '0;
                     state   <= SHIFT;
                  end
               end
            end

            SHIFT: begin
               if (cs_n) begin
                  // cs_n rose before the word was complete. Drop the partial word.
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else begin
                  shift   <= word_next;
                  bit_cnt <= bit_cnt + ONE;
                  if (word_done)
                     state <= DONE;
               end
            end

            // Extra low slots after a full word are ignored. One high slot is
            // enough to get ready for the next frame.
            DONE: begin
               if (cs_n)
                  state <= IDLE;
            end

            default: state <= WAIT_HIGH;
         endcase

         // Output stage. On an edge where the downstream accepts a word and a
         // new word completes, the new word is loaded straight away.
         if (data_valid && data_ready)
            data_valid <= 1'b0;

         if (word_done) begin
            if (!data_valid || data_ready) begin
               data_out   <= word_next;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_rx_16.sv
module tb_spi_rx_16;

   logic        sclk = 1'b0;
   logic        reset;
   logic        mosi;
   logic        cs_n;
   logic        data_ready;
   logic [15:0] data_out;
   logic        data_valid;
   logic        frame_err;
   logic        overrun;
   logic        rx_active;

   int total  = 0;
   int passed = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int vld_cnt = 0;

   spi_rx_16 #(.DATA_W(16), .LEAD_BITS(1)) dut (
      .sclk       (sclk),
      .reset      (reset),
      .mosi       (mosi),
      .cs_n       (cs_n),
      .data_ready (data_ready),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .rx_active  (rx_active)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      string       name;
      logic [15:0] word;
      logic        lead;
      logic [15:0] exp_out;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One rising edge. Inputs change on the falling edge, and outputs are
   // sampled 1 time unit after the rising edge.
   task automatic slot(input logic cs, input logic m, input logic r);
      @(negedge sclk);
      cs_n = cs;
      mosi = m;
      data_ready = r;
      @(posedge sclk);
      #1;
      fe_cnt  += int'(frame_err);
      ov_cnt  += int'(overrun);
      vld_cnt += int'(data_valid);
   endtask

   task automatic send_frame(input logic [15:0] word, input logic lead,
                             input logic r_body, input logic r_last);
      slot(1'b0, lead, r_body);
      for (int i = 15; i >= 1; i--) slot(1'b0, word[i], r_body);
      slot(1'b0, word[0], r_last);
   endtask

   task automatic clr();
      fe_cnt = 0; ov_cnt = 0; vld_cnt = 0;
   endtask

   initial begin
      vecs[0] = '{"a5c3",   16'hA5C3, 1'b0, 16'hA5C3};
      vecs[1] = '{"zero",   16'h0000, 1'b1, 16'h0000};
      vecs[2] = '{"msb",    16'h8000, 1'b1, 16'h8000};
      vecs[3] = '{"x7ffe",  16'h7FFE, 1'b0, 16'h7FFE};
      vecs[4] = '{"x1234",  16'h1234, 1'b0, 16'h1234};

      // Reset
      reset = 1'b1; cs_n = 1'b0; mosi = 1'b1; data_ready = 1'b0;
      repeat (3) @(posedge sclk);
      #1;
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_valid",    32'(data_valid), 32'h0);
      check("rst_frame_err",32'(frame_err), 32'h0);
      check("rst_overrun",  32'(overrun), 32'h0);
      check("rst_rx_active",32'(rx_active), 32'h0);
      reset = 1'b0;

      // With cs_n already low when reset releases, nothing should happen.
      clr();
      repeat (4) slot(1'b0, 1'b1, 1'b1);
      slot(1'b1, 1'b0, 1'b1);
      check("wait_high_quiet", 32'(fe_cnt + vld_cnt + int'(rx_active)), 32'h0);

      // Single words sent with the transmitter's timing, from the table
      for (int v = 0; v < 5; v++) begin
         clr();
         send_frame(vecs[v].word, vecs[v].lead, 1'b1, 1'b1);
         check({vecs[v].name, "_valid"}, 32'(data_valid), 32'h1);
         check({vecs[v].name, "_data"},  32'(data_out), 32'(vecs[v].exp_out));
         slot(1'b1, 1'b0, 1'b1);
         check({vecs[v].name, "_valid_1cyc"}, 32'(vld_cnt), 32'h1);
         check({vecs[v].name, "_flags"}, 32'(fe_cnt + ov_cnt), 32'h0);
      end

      // Back-to-back frames with a single high cycle between them
      clr();
      send_frame(16'h1234, 1'b0, 1'b1, 1'b1);
      check("b2b_w0", 32'(data_out), 32'h1234);
      slot(1'b1, 1'b0, 1'b1);
      send_frame(16'hFFFF, 1'b1, 1'b1, 1'b1);
      check("b2b_w1", 32'(data_out), 32'hFFFF);
      check("b2b_w1_valid", 32'(data_valid), 32'h1);
      slot(1'b1, 1'b0, 1'b1);
      check("b2b_pulses", 32'(vld_cnt), 32'h2);
      check("b2b_flags", 32'(fe_cnt + ov_cnt), 32'h0);

      // Truncated frame (9 low edges), then a good frame
      clr();
      repeat (9) slot(1'b0, 1'b1, 1'b1);
      check("trunc_active", 32'(rx_active), 32'h1);
      slot(1'b1, 1'b0, 1'b1);
      check("trunc_ferr_now", 32'(frame_err), 32'h1);
      slot(1'b1, 1'b0, 1'b1);
      check("trunc_ferr_pulse", 32'(fe_cnt), 32'h1);
      check("trunc_no_valid", 32'(vld_cnt), 32'h0);
      send_frame(16'h0001, 1'b0, 1'b1, 1'b1);
      check("trunc_recover", 32'(data_out), 32'h0001);
      check("trunc_recover_v", 32'(data_valid), 32'h1);
      slot(1'b1, 1'b0, 1'b1);

      // Overrun
      clr();
      send_frame(16'h00FF, 1'b0, 1'b0, 1'b0);
      slot(1'b1, 1'b0, 1'b0);
      check("ovr_held", 32'(data_valid), 32'h1);
      send_frame(16'hAAAA, 1'b0, 1'b0, 1'b0);
      check("ovr_pulse", 32'(overrun), 32'h1);
      check("ovr_keep_data", 32'(data_out), 32'h00FF);
      slot(1'b1, 1'b0, 1'b0);
      check("ovr_one_cycle", 32'(ov_cnt), 32'h1);
      check("ovr_pre_accept", 32'(data_out), 32'h00FF);
      slot(1'b1, 1'b0, 1'b1);
      check("ovr_accepted", 32'(data_valid), 32'h0);
      check("ovr_data_kept", 32'(data_out), 32'h00FF);
      check("ovr_no_ferr", 32'(fe_cnt), 32'h0);

      // Accept and completion on the same edge
      clr();
      send_frame(16'h1111, 1'b0, 1'b0, 1'b0);
      slot(1'b1, 1'b0, 1'b0);
      check("same_hold", 32'(data_out), 32'h1111);
      send_frame(16'h2222, 1'b0, 1'b0, 1'b1);
      check("same_data", 32'(data_out), 32'h2222);
      check("same_valid", 32'(data_valid), 32'h1);
      check("same_no_ovr", 32'(ov_cnt), 32'h0);
      slot(1'b1, 1'b0, 1'b1);
      check("same_drain", 32'(data_valid), 32'h0);

      // Reset in the middle of a frame
      clr();
      slot(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) slot(1'b0, i[0], 1'b1);
      check("mid_active", 32'(rx_active), 32'h1);
      @(negedge sclk);
      reset = 1'b1; cs_n = 1'b0; mosi = 1'b1;
      @(posedge sclk);
      #1;
      check("mid_rst_outs", 32'({data_out, data_valid, frame_err, overrun, rx_active}), 32'h0);
      reset = 1'b0;
      repeat (11) slot(1'b0, 1'b1, 1'b1);
      slot(1'b1, 1'b0, 1'b1);
      check("mid_no_ferr", 32'(fe_cnt), 32'h0);
      check("mid_no_valid", 32'(vld_cnt), 32'h0);
      send_frame(16'h8001, 1'b0, 1'b1, 1'b1);
      check("mid_8001", 32'(data_out), 32'h8001);
      check("mid_8001_v", 32'(data_valid), 32'h1);
      slot(1'b1, 1'b0, 1'b1);

      // 20-slot frame: the word arrives at slot 16, and slots 17-19 are ignored
      clr();
      send_frame(16'h5A5A, 1'b1, 1'b1, 1'b1);
      check("long_data", 32'(data_out), 32'h5A5A);
      check("long_valid", 32'(data_valid), 32'h1);
      repeat (3) slot(1'b0, 1'b1, 1'b1);
      check("long_idle_active", 32'(rx_active), 32'h0);
      slot(1'b1, 1'b0, 1'b1);
      check("long_one_word", 32'(vld_cnt), 32'h1);
      check("long_flags", 32'(fe_cnt + ov_cnt), 32'h0);
      check("long_data_kept", 32'(data_out), 32'h5A5A);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
